mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter N_PORTS, default 2, number of PicoRV32 native memory ports (1..8).
REQ-002 SHALL take parameter LOCK_MAX, default 4, maximum consecutive locked grants to one port (1..15).
REQ-003 SHALL derive localparam PORT_BITS = max(1, clog2(N_PORTS)).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 up_valid  in  N_PORTS  per-port request (mem_valid).
REQ-007 up_addr / up_wdata  in  32*N_PORTS each  per-port address / write data; port p occupies bits [32p+31:32p].
REQ-008 up_wstrb  in  4*N_PORTS  per-port byte strobes; all zero = read.
REQ-009 up_lock  in  N_PORTS  per-port request to keep the grant for the next transaction.
REQ-010 up_ready  out  N_PORTS  per-port one-cycle completion pulse.
REQ-011 up_rdata  out  32*N_PORTS  per-port read data, valid while up_ready[p] is high.
REQ-012 dn_valid, dn_addr[31:0], dn_wdata[31:0], dn_wstrb[3:0]  out  downstream request.
REQ-013 dn_ready  in  1; dn_rdata  in  32  downstream completion and read data.
REQ-014 grant_id  out  PORT_BITS; busy  out  1  current owner and not-IDLE flag.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one transaction at a time.
REQ-016 IDLE: if any up_valid is high, SHALL select a winner, register its addr/wdata/wstrb onto dn_*, set grant_id, and enter ISSUE; otherwise stay IDLE.
REQ-017 ISSUE: dn_valid SHALL be high with dn_* stable; on dn_ready high SHALL capture dn_rdata into up_rdata[grant_id], pulse up_ready[grant_id] in the next cycle, and enter RESP.
REQ-018 RESP: SHALL last exactly one cycle, grant nothing, and return to IDLE.
REQ-019 Latency: request seen in IDLE cycle N gives dn_valid in N+1; dn_ready in cycle M gives up_ready in M+1; earliest re-arbitration is M+2.
REQ-020 Arbitration SHALL be work-conserving round-robin: search starts at (last_grant+1) mod N_PORTS and takes the first port with up_valid high; idle ports are skipped.
REQ-021 With all ports continuously requesting, grants SHALL follow 0,1,...,N_PORTS-1,0,...
REQ-022 up_ready SHALL never be high for more than one port or for more than one cycle per transaction.
REQ-023 up_rdata of non-granted ports SHALL hold their previous values.
REQ-024 dn_valid SHALL be low in IDLE and RESP.
REQ-025 An up_valid deasserted mid-ISSUE SHALL be ignored; the transaction completes normally.
REQ-026 With N_PORTS=1 the arbiter SHALL degenerate to the same FSM with grant_id fixed at 0.

Reset
REQ-027 While resetn is low, SHALL force state IDLE, dn_valid=0, dn_addr/dn_wdata/dn_wstrb=0, up_ready=0, up_rdata=0, grant_id=0, busy=0, last_grant=N_PORTS-1 (port 0 highest first), lock count=0.
REQ-028 Reset asserted mid-ISSUE SHALL abort the transaction with no up_ready pulse; after release, arbitration restarts from port 0.

Configuration
REQ-029 Macro MEM_ARBITER_LOCK_EN SHALL compile in locking: if up_lock[grant_id] is high at the dn_ready cycle and lock count < LOCK_MAX, the next IDLE SHALL grant the same port when it is requesting, increment lock count, and leave last_grant unchanged.
REQ-030 With locking, lock count SHALL reset to 0 and normal round-robin SHALL resume when the locked port is not requesting in IDLE, when up_lock is low, or when LOCK_MAX is reached.
REQ-031 Without MEM_ARBITER_LOCK_EN, up_lock SHALL be ignored and no lock counter SHALL be synthesised.

Structure
REQ-032 Package mem_arbiter_pkg SHALL hold the FSM state encoding (IDLE/ISSUE/RESP) and the 32-bit address/data width constants.
REQ-033 Combinational sub-module rr_pick SHALL take (request vector, last_grant) and return (found, index), parametrised on N_PORTS.

Verification
REQ-034 N_PORTS=2, both ports read continuously, dn_ready one cycle after dn_valid -> grant_id sequence 0,1,0,1; each up_ready is a single-cycle pulse carrying the matching dn_rdata.
REQ-035 N_PORTS=4, only port 2 requests, write addr 0x100 wdata 0xDEADBEEF wstrb 0xF -> dn_* match exactly; up_ready[2] only; ports 0, 1 and 3 untouched.
REQ-036 dn_ready held low 5 cycles -> dn_valid and dn_* stable throughout; up_ready appears in the cycle after dn_ready.
REQ-037 resetn pulsed low during ISSUE -> dn_valid=0 and up_ready=0 immediately; first grant after release goes to port 0.
REQ-038 MEM_ARBITER_LOCK_EN, LOCK_MAX=4, port 1 locked while port 0 also requests -> port 1 gets 5 consecutive grants (1 plus 4 locked), then port 0.
REQ-039 Ports 0 and 3 request while port 1 idle, last_grant=0 -> port 3 granted with no idle cycle for skipped ports.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the PicoRV32 native-memory arbiter.
//   - ADDR_W / DATA_W / STRB_W : fixed 32-bit bus widths
//   - state_t                  : arbiter FSM encoding (IDLE/ISSUE/RESP)
//   - port_bits()              : index width for a given port count (min 1)
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic int unsigned port_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   Ports:
//     req        in  N_PORTS    request vector
//     last_grant in  PORT_BITS  most recently granted port
//     found      out 1          any request present
//     index      out PORT_BITS  first requester after last_grant (wrapping)
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned PORT_BITS = 1
) (
    input  logic [N_PORTS-1:0]   req,
    input  logic [PORT_BITS-1:0] last_grant,
    output logic                 found,
    output logic [PORT_BITS-1:0] index
);

    int unsigned cand;

    // Walk offsets 1..N_PORTS from last_grant; offset N_PORTS wraps back to
    // last_grant itself so a lone requester is still served.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = (32'(last_grant) + i) % N_PORTS;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand[PORT_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing one downstream PicoRV32 native memory port
//   between N_PORTS upstream masters, one transaction at a time
//   (IDLE -> ISSUE -> RESP -> IDLE).
//   Optional build macro: MEM_ARBITER_LOCK_EN -- lets a master keep the
//   grant for up to LOCK_MAX extra consecutive transactions via up_lock.
//   Ports:
//     clk, resetn          clock, async active-low reset
//     up_valid/up_lock     per-port request / lock request     [N_PORTS]
//     up_addr/up_wdata     per-port address / write data       [32*N_PORTS]
//     up_wstrb             per-port byte strobes (0 = read)    [4*N_PORTS]
//     up_ready/up_rdata    per-port completion pulse / rdata
//     dn_valid/addr/wdata/wstrb  downstream request (registered)
//     dn_ready/dn_rdata    downstream completion / read data
//     grant_id/busy        current owner / FSM not in IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_PORTS-1:0]       up_valid,
    input  logic [ADDR_W*N_PORTS-1:0] up_addr,
    input  logic [DATA_W*N_PORTS-1:0] up_wdata,
    input  logic [STRB_W*N_PORTS-1:0] up_wstrb,
    input  logic [N_PORTS-1:0]       up_lock,
    output logic [N_PORTS-1:0]       up_ready,
    output logic [DATA_W*N_PORTS-1:0] up_rdata,
    output logic                     dn_valid,
    output logic [ADDR_W-1:0]        dn_addr,
    output logic [DATA_W-1:0]        dn_wdata,
    output logic [STRB_W-1:0]        dn_wstrb,
    input  logic                     dn_ready,
    input  logic [DATA_W-1:0]        dn_rdata,
    output logic [port_bits(N_PORTS)-1:0] grant_id,
    output logic                     busy
);

    localparam int unsigned PORT_BITS = port_bits(N_PORTS);

    state_t               state;
    logic [PORT_BITS-1:0] last_grant;
    logic                 rr_found;
    logic [PORT_BITS-1:0] rr_idx;
    logic                 sel_found;
    logic [PORT_BITS-1:0] sel_idx;

    rr_pick #(
        .N_PORTS   (N_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_rr_pick (
        .req        (up_valid),
        .last_grant (last_grant),
        .found      (rr_found),
        .index      (rr_idx)
    );

`ifdef MEM_ARBITER_LOCK_EN
    logic [3:0] lock_cnt;
    logic       lock_hold;   // previous owner asked to keep the grant
    logic       sel_locked;

    // A pending lock overrides round-robin only if the owner is requesting
    // again; otherwise the normal search result is used.
    always_comb begin
        sel_found  = rr_found;
        sel_idx    = rr_idx;
        sel_locked = 1'b0;
        if (lock_hold && up_valid[grant_id]) begin
            sel_found  = 1'b1;
            sel_idx    = grant_id;
            sel_locked = 1'b1;
        end
    end
`else
    logic                   unused_lock;
    localparam int unsigned unused_lock_max = LOCK_MAX;
    assign unused_lock = ^up_lock;

    always_comb begin
        sel_found = rr_found;
        sel_idx   = rr_idx;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            dn_valid   <= 1'b0;
            dn_addr    <= '0;
            dn_wdata   <= '0;
            dn_wstrb   <= '0;
            up_ready   <= '0;
            up_rdata   <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            // Makes port 0 the first candidate after reset.
            last_grant <= PORT_BITS'(N_PORTS - 1);
`ifdef MEM_ARBITER_LOCK_EN
            lock_cnt   <= '0;
            lock_hold  <= 1'b0;
`endif
        end else begin
            up_ready <= '0;
            case (state)
                ST_IDLE: begin
`ifdef MEM_ARBITER_LOCK_EN
                    lock_hold <= 1'b0;
                    if (!sel_locked) begin
                        lock_cnt <= '0;
                    end
`endif
                    if (sel_found) begin
                        dn_valid <= 1'b1;
                        dn_addr  <= up_addr[ADDR_W*sel_idx +: ADDR_W];
                        dn_wdata <= up_wdata[DATA_W*sel_idx +: DATA_W];
                        dn_wstrb <= up_wstrb[STRB_W*sel_idx +: STRB_W];
                        grant_id <= sel_idx;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
`ifdef MEM_ARBITER_LOCK_EN
                        // Locked re-grants leave the round-robin pointer alone.
                        if (sel_locked) begin
                            lock_cnt <= lock_cnt + 4'd1;
                        end else begin
                            last_grant <= sel_idx;
                        end
`else
                        last_grant <= sel_idx;
`endif
                    end
                end

                ST_ISSUE: begin
                    if (dn_ready) begin
                        dn_valid <= 1'b0;
                        up_ready[grant_id] <= 1'b1;
                        up_rdata[DATA_W*grant_id +: DATA_W] <= dn_rdata;
                        state <= ST_RESP;
`ifdef MEM_ARBITER_LOCK_EN
                        lock_hold <= up_lock[grant_id] && (lock_cnt < 4'(LOCK_MAX));
`endif
                    end
                end

                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    dn_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a 2-port instance (default parameters)
//   and a 4-port instance sharing clock and reset. Inputs change and
//   outputs are sampled on the falling clock edge.
//   Honours MEM_ARBITER_LOCK_EN when building the expected lock sequence.
module tb_mem_arbiter;

    logic clk;
    logic resetn;

    // 2-port instance
    logic [1:0]   up_valid2, up_lock2, up_ready2;
    logic [63:0]  up_addr2, up_wdata2, up_rdata2;
    logic [7:0]   up_wstrb2;
    logic         dn_valid2, dn_ready2, busy2;
    logic [31:0]  dn_addr2, dn_wdata2, dn_rdata2;
    logic [3:0]   dn_wstrb2;
    logic [0:0]   grant_id2;

    // 4-port instance
    logic [3:0]   up_valid4, up_lock4, up_ready4;
    logic [127:0] up_addr4, up_wdata4, up_rdata4;
    logic [15:0]  up_wstrb4;
    logic         dn_valid4, dn_ready4, busy4;
    logic [31:0]  dn_addr4, dn_wdata4, dn_rdata4;
    logic [3:0]   dn_wstrb4;
    logic [1:0]   grant_id4;

    int n_cmp;
    int n_err;

    mem_arbiter u_dut2 (
        .clk(clk), .resetn(resetn),
        .up_valid(up_valid2), .up_addr(up_addr2), .up_wdata(up_wdata2),
        .up_wstrb(up_wstrb2), .up_lock(up_lock2),
        .up_ready(up_ready2), .up_rdata(up_rdata2),
        .dn_valid(dn_valid2), .dn_addr(dn_addr2), .dn_wdata(dn_wdata2),
        .dn_wstrb(dn_wstrb2), .dn_ready(dn_ready2), .dn_rdata(dn_rdata2),
        .grant_id(grant_id2), .busy(busy2)
    );

    mem_arbiter #(.N_PORTS(4), .LOCK_MAX(4)) u_dut4 (
        .clk(clk), .resetn(resetn),
        .up_valid(up_valid4), .up_addr(up_addr4), .up_wdata(up_wdata4),
        .up_wstrb(up_wstrb4), .up_lock(up_lock4),
        .up_ready(up_ready4), .up_rdata(up_rdata4),
        .dn_valid(dn_valid4), .dn_addr(dn_addr4), .dn_wdata(dn_wdata4),
        .dn_wstrb(dn_wstrb4), .dn_ready(dn_ready4), .dn_rdata(dn_rdata4),
        .grant_id(grant_id4), .busy(busy4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bounded wait for the 4-port downstream request.
    task automatic wait_dn4();
        for (int t = 0; t < 20 && !dn_valid4; t++) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (dn_valid2 !== 1'b0 || dn_valid4 !== 1'b0) begin n_err++;
            $display("FAIL reset_dn_valid: got %b/%b expected 0/0", dn_valid2, dn_valid4); end
        n_cmp++; if (dn_addr4 !== 32'h0 || dn_wdata4 !== 32'h0 || dn_wstrb4 !== 4'h0) begin n_err++;
            $display("FAIL reset_dn_bus: got %h %h %h expected zeros", dn_addr4, dn_wdata4, dn_wstrb4); end
        n_cmp++; if (up_ready2 !== 2'b0 || up_ready4 !== 4'b0) begin n_err++;
            $display("FAIL reset_up_ready: got %b/%b expected 0", up_ready2, up_ready4); end
        n_cmp++; if (up_rdata4 !== 128'h0 || up_rdata2 !== 64'h0) begin n_err++;
            $display("FAIL reset_up_rdata: got %h expected 0", up_rdata4); end
        n_cmp++; if (grant_id4 !== 2'd0 || grant_id2 !== 1'b0) begin n_err++;
            $display("FAIL reset_grant_id: got %0d/%0d expected 0", grant_id2, grant_id4); end
        n_cmp++; if (busy2 !== 1'b0 || busy4 !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b/%b expected 0", busy2, busy4); end
        resetn = 1'b1;
    endtask

    // Both ports of the 2-port instance read continuously.
    task automatic test_rr_two_ports();
        int p;
        logic [31:0] rd;
        up_addr2  = {32'h0000_2004, 32'h0000_2000};
        up_wstrb2 = '0;
        up_valid2 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            p  = k % 2;
            rd = 32'hA000_0000 + 32'(k);
            for (int t = 0; t < 20 && !dn_valid2; t++) @(negedge clk);
            n_cmp++; if (dn_valid2 !== 1'b1) begin n_err++;
                $display("FAIL rr2_dn_valid[%0d]: got %b expected 1", k, dn_valid2); end
            n_cmp++; if (int'(grant_id2) !== p) begin n_err++;
                $display("FAIL rr2_grant[%0d]: got %0d expected %0d", k, grant_id2, p); end
            n_cmp++; if (dn_addr2 !== up_addr2[p*32 +: 32] || dn_wstrb2 !== 4'h0) begin n_err++;
                $display("FAIL rr2_dn_addr[%0d]: got %h expected %h", k, dn_addr2, up_addr2[p*32 +: 32]); end
            dn_rdata2 = rd;
            dn_ready2 = 1'b1;
            @(negedge clk);
            dn_ready2 = 1'b0;
            n_cmp++; if (up_ready2 !== 2'(1 << p)) begin n_err++;
                $display("FAIL rr2_up_ready[%0d]: got %b expected %b", k, up_ready2, 2'(1 << p)); end
            n_cmp++; if (up_rdata2[p*32 +: 32] !== rd) begin n_err++;
                $display("FAIL rr2_up_rdata[%0d]: got %h expected %h", k, up_rdata2[p*32 +: 32], rd); end
            @(negedge clk);
            n_cmp++; if (up_ready2 !== 2'b00) begin n_err++;
                $display("FAIL rr2_pulse_len[%0d]: got %b expected 00", k, up_ready2); end
        end
        up_valid2 = 2'b00;
    endtask

    // Only port 2 of the 4-port instance issues a write.
    task automatic test_single_port_write();
        up_addr4[64 +: 32]  = 32'h0000_0100;
        up_wdata4[64 +: 32] = 32'hDEAD_BEEF;
        up_wstrb4[8 +: 4]   = 4'hF;
        up_valid4 = 4'b0100;
        wait_dn4();
        n_cmp++; if (dn_valid4 !== 1'b1 || grant_id4 !== 2'd2) begin n_err++;
            $display("FAIL wr_grant: got v=%b id=%0d expected v=1 id=2", dn_valid4, grant_id4); end
        n_cmp++; if (dn_addr4 !== 32'h100 || dn_wdata4 !== 32'hDEAD_BEEF || dn_wstrb4 !== 4'hF) begin n_err++;
            $display("FAIL wr_dn_bus: got %h %h %h expected 00000100 deadbeef f", dn_addr4, dn_wdata4, dn_wstrb4); end
        n_cmp++; if (busy4 !== 1'b1) begin n_err++;
            $display("FAIL wr_busy: got %b expected 1", busy4); end
        dn_rdata4 = 32'hCAFE_F00D;
        dn_ready4 = 1'b1;
        @(negedge clk);
        dn_ready4 = 1'b0;
        up_valid4 = 4'b0000;
        n_cmp++; if (up_ready4 !== 4'b0100) begin n_err++;
            $display("FAIL wr_up_ready: got %b expected 0100", up_ready4); end
        n_cmp++; if (up_rdata4 !== {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0}) begin n_err++;
            $display("FAIL wr_up_rdata: got %h expected port2=cafef00d others 0", up_rdata4); end
        @(negedge clk);
        n_cmp++; if (up_ready4 !== 4'b0000 || busy4 !== 1'b0 || dn_valid4 !== 1'b0) begin n_err++;
            $display("FAIL wr_idle: got rdy=%b busy=%b v=%b expected 0", up_ready4, busy4, dn_valid4); end
    endtask

    // Downstream stalls 5 cycles; requester drops up_valid mid-ISSUE.
    task automatic test_stall();
        up_addr4[0 +: 32]  = 32'h0000_0200;
        up_wdata4[0 +: 32] = 32'h1111_2222;
        up_wstrb4[0 +: 4]  = 4'h3;
        up_valid4 = 4'b0001;
        wait_dn4();
        n_cmp++; if (dn_valid4 !== 1'b1 || grant_id4 !== 2'd0) begin n_err++;
            $display("FAIL stall_grant: got v=%b id=%0d expected v=1 id=0", dn_valid4, grant_id4); end
        up_valid4 = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (dn_valid4 !== 1'b1 || dn_addr4 !== 32'h200 || dn_wdata4 !== 32'h1111_2222
                         || dn_wstrb4 !== 4'h3 || up_ready4 !== 4'b0) begin n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b a=%h d=%h s=%h r=%b", c, dn_valid4,
                         dn_addr4, dn_wdata4, dn_wstrb4, up_ready4); end
        end
        dn_rdata4 = 32'h0BAD_F00D;
        dn_ready4 = 1'b1;
        @(negedge clk);
        dn_ready4 = 1'b0;
        n_cmp++; if (up_ready4 !== 4'b0001 || up_rdata4[0 +: 32] !== 32'h0BAD_F00D) begin n_err++;
            $display("FAIL stall_done: got rdy=%b rd=%h expected 0001 0badf00d", up_ready4, up_rdata4[0 +: 32]); end
        @(negedge clk);
        n_cmp++; if (dn_valid4 !== 1'b0 || up_ready4 !== 4'b0) begin n_err++;
            $display("FAIL stall_after: got v=%b rdy=%b expected 0", dn_valid4, up_ready4); end
    endtask

    // last_grant=0, ports 0 and 3 request: port 3 wins with no idle cycles,
    // then port 0 at the earliest re-arbitration slot.
    task automatic test_back_to_back();
        up_addr4[96 +: 32] = 32'h0000_0300;
        up_wstrb4[12 +: 4] = 4'h0;
        up_wstrb4[0 +: 4]  = 4'h0;
        up_valid4 = 4'b1001;
        @(negedge clk);
        n_cmp++; if (dn_valid4 !== 1'b1 || grant_id4 !== 2'd3 || dn_addr4 !== 32'h300) begin n_err++;
            $display("FAIL skip_grant: got v=%b id=%0d a=%h expected 1 3 00000300", dn_valid4, grant_id4, dn_addr4); end
        dn_rdata4 = 32'h3333_3333;
        dn_ready4 = 1'b1;
        @(negedge clk);
        dn_ready4 = 1'b0;
        up_valid4 = 4'b0001;
        n_cmp++; if (up_ready4 !== 4'b1000 || up_rdata4[96 +: 32] !== 32'h3333_3333) begin n_err++;
            $display("FAIL skip_done: got rdy=%b rd=%h expected 1000 33333333", up_ready4, up_rdata4[96 +: 32]); end
        @(negedge clk);
        n_cmp++; if (dn_valid4 !== 1'b0) begin n_err++;
            $display("FAIL b2b_idle_gap: got v=%b expected 0", dn_valid4); end
        @(negedge clk);
        n_cmp++; if (dn_valid4 !== 1'b1 || grant_id4 !== 2'd0) begin n_err++;
            $display("FAIL b2b_regrant: got v=%b id=%0d expected 1 0", dn_valid4, grant_id4); end
        dn_rdata4 = 32'h4444_4444;
        dn_ready4 = 1'b1;
        @(negedge clk);
        dn_ready4 = 1'b0;
        up_valid4 = 4'b0000;
        n_cmp++; if (up_ready4 !== 4'b0001 || up_rdata4[96 +: 32] !== 32'h3333_3333) begin n_err++;
            $display("FAIL b2b_done: got rdy=%b p3=%h expected 0001 33333333", up_ready4, up_rdata4[96 +: 32]); end
        @(negedge clk);
    endtask

    // Reset during ISSUE aborts cleanly; port 0 is first afterwards.
    task automatic test_reset_mid_issue();
        up_valid4 = 4'b1100;
        wait_dn4();
        n_cmp++; if (grant_id4 !== 2'd2) begin n_err++;
            $display("FAIL rst_pre_grant: got %0d expected 2", grant_id4); end
        dn_rdata4 = 32'h5555_5555;
        dn_ready4 = 1'b1;
        resetn    = 1'b0;
        #1;
        n_cmp++; if (dn_valid4 !== 1'b0 || up_ready4 !== 4'b0 || busy4 !== 1'b0) begin n_err++;
            $display("FAIL rst_abort: got v=%b rdy=%b busy=%b expected 0", dn_valid4, up_ready4, busy4); end
        @(negedge clk);
        n_cmp++; if (up_ready4 !== 4'b0 || up_rdata4 !== 128'h0) begin n_err++;
            $display("FAIL rst_no_pulse: got rdy=%b rd=%h expected 0", up_ready4, up_rdata4); end
        dn_ready4 = 1'b0;
        up_valid4 = 4'b1101;
        resetn    = 1'b1;
        @(negedge clk);
        n_cmp++; if (dn_valid4 !== 1'b1 || grant_id4 !== 2'd0 || dn_addr4 !== 32'h200) begin n_err++;
            $display("FAIL rst_first_grant: got v=%b id=%0d a=%h expected 1 0 00000200", dn_valid4, grant_id4, dn_addr4); end
        dn_ready4 = 1'b1;
        @(negedge clk);
        dn_ready4 = 1'b0;
        up_valid4 = 4'b0000;
        @(negedge clk);
    endtask

    // Port 1 asks to lock while port 0 also requests; last_grant is 0.
    task automatic test_lock();
        int exp_seq[6];
`ifdef MEM_ARBITER_LOCK_EN
        exp_seq = '{1, 1, 1, 1, 1, 0};
`else
        exp_seq = '{1, 0, 1, 0, 1, 0};
`endif
        up_lock4  = 4'b0010;
        up_valid4 = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            wait_dn4();
            n_cmp++; if (dn_valid4 !== 1'b1 || int'(grant_id4) !== exp_seq[k]) begin n_err++;
                $display("FAIL lock_seq[%0d]: got v=%b id=%0d expected 1 %0d", k, dn_valid4, grant_id4, exp_seq[k]); end
            dn_ready4 = 1'b1;
            @(negedge clk);
            dn_ready4 = 1'b0;
            if (k == 5) up_valid4 = 4'b0000;
            @(negedge clk);
        end
        up_lock4 = 4'b0000;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        resetn = 1'b1;
        up_valid2 = '0; up_lock2 = '0; up_addr2 = '0; up_wdata2 = '0; up_wstrb2 = '0;
        dn_ready2 = 1'b0; dn_rdata2 = '0;
        up_valid4 = '0; up_lock4 = '0; up_addr4 = '0; up_wdata4 = '0; up_wstrb4 = '0;
        dn_ready4 = 1'b0; dn_rdata4 = '0;
        @(negedge clk);
        test_reset();
        test_rr_two_ports();
        test_single_port_write();
        test_stall();
        test_back_to_back();
        test_reset_mid_issue();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
